// File: rtl/serial_frame_rx_if.sv
// ---------------------------------------------------------------------------
// serial_frame_rx_if
//   Bundles the serial input side and the parallel result side of the
//   serial frame receiver.
//   Signals:
//     sin         serial data from the shift stage; idle level 1
//     bit_en      one-cycle bit strobe; sin is only meaningful with it
//     dout        last good received word (WIDTH bits)
//     dout_valid  1-cycle pulse; dout updated on the same edge
//     frame_err   1-cycle pulse; stop bit sampled as 0
//     parity_err  1-cycle pulse; parity mismatch
//     busy        receiver is inside a frame
//   Modports:
//     master  the upstream driver / downstream consumer side
//     slave   the receiver itself
// ---------------------------------------------------------------------------
interface serial_frame_rx_if #(
    parameter int unsigned WIDTH = 4
);
    logic             sin;
    logic             bit_en;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             frame_err;
    logic             parity_err;
    logic             busy;

    modport master (
        output sin,
        output bit_en,
        input  dout,
        input  dout_valid,
        input  frame_err,
        input  parity_err,
        input  busy
    );

    modport slave (
        input  sin,
        input  bit_en,
        output dout,
        output dout_valid,
        output frame_err,
        output parity_err,
        output busy
    );
endinterface

// File: rtl/serial_frame_rx.sv
// ---------------------------------------------------------------------------
// serial_frame_rx
//   Serial-to-parallel frame receiver for the LSB-first bitstream of the
//   4-bit shift-register stage. A frame is: start bit (0), WIDTH data bits
//   LSB first, optional parity bit, stop bit (1). Bits are taken only on
//   clock edges where bit_en is high.
//   Parameters:
//     WIDTH   data bits per frame, 1..16
//     PARITY  0 = none, 1 = even, 2 = odd
//   Ports:
//     clk     rising-edge clock
//     reset   asynchronous, active-high reset
//     rx      serial_frame_rx_if.slave: sin, bit_en in;
//             dout, dout_valid, frame_err, parity_err, busy out
// ---------------------------------------------------------------------------
module serial_frame_rx #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned PARITY = 0
) (
    input  logic            clk,
    input  logic            reset,
    serial_frame_rx_if.slave rx
);

    localparam int unsigned    CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PAR,
        STOP
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             par_ok_q, par_ok_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;
    logic             frame_err_q, frame_err_d;
    logic             parity_err_q, parity_err_d;

    // Parity of the received data combined with the parity bit on sin.
    logic             par_sum;
    assign par_sum = (^sr_q) ^ rx.sin;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            sr_q         <= '0;
            cnt_q        <= '0;
            par_ok_q     <= 1'b1;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sr_q         <= sr_d;
            cnt_q        <= cnt_d;
            par_ok_q     <= par_ok_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        sr_d         = sr_q;
        cnt_d        = cnt_q;
        par_ok_d     = par_ok_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        parity_err_d = 1'b0;

        if (rx.bit_en) begin
            unique case (state_q)
                IDLE: begin
                    if (!rx.sin) begin
                        state_d  = DATA;
                        cnt_d    = '0;
                        // Without a parity bit the frame is always parity-clean.
                        par_ok_d = 1'b1;
                    end
                end

                DATA: begin
                    // New bit enters at the MSB so the first bit ends at bit 0;
                    // written as shifts so WIDTH=1 needs no special slice.
                    sr_d  = (sr_q >> 1) | (WIDTH'(rx.sin) << (WIDTH - 1));
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        state_d = (PARITY != 0) ? PAR : STOP;
                    end
                end

                PAR: begin
                    par_ok_d = (PARITY == 2) ? par_sum : ~par_sum;
                    state_d  = STOP;
                end

                STOP: begin
                    state_d = IDLE;
                    if (!rx.sin) begin
                        frame_err_d = 1'b1;
                    end else if (par_ok_q) begin
                        dout_d       = sr_q;
                        dout_valid_d = 1'b1;
                    end else begin
                        parity_err_d = 1'b1;
                    end
                end

                default: state_d = IDLE;
            endcase
        end
    end

    assign rx.dout       = dout_q;
    assign rx.dout_valid = dout_valid_q;
    assign rx.frame_err  = frame_err_q;
    assign rx.parity_err = parity_err_q;
    assign rx.busy       = (state_q != IDLE);

endmodule
